// File: rtl/mem_rd_streamer_if.sv
// mem_rd_streamer_if: SRAM read port plus valid/ready output stream of the streamer
interface mem_rd_streamer_if #(
    parameter int WIDTH = 32,
    parameter int SIZE = 256
);
    localparam int AW = $clog2(SIZE);
    logic             mem_cenb;
    logic             mem_wenb;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_d;
    logic [WIDTH-1:0] mem_q;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    modport master (
        output mem_cenb, mem_wenb, mem_addr, mem_d, m_valid, m_data,
        input  mem_q, m_ready
    );
    modport slave (
        input  mem_cenb, mem_wenb, mem_addr, mem_d, m_valid, m_data,
        output mem_q, m_ready
    );
endinterface

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer: reads LEN consecutive SRAM words from BASE into a valid/ready stream
module mem_rd_streamer #(
    parameter int WIDTH = 32,
    parameter int SIZE = 256,
    localparam int AW = $clog2(SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_i,
    input  logic [AW:0]       len_i,
    output logic              busy_o,
    output logic              done_o,
    mem_rd_streamer_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q;
    logic             done_q, inflight_q, wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic [AW:0]      len_q, issued_q, popped_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] buf_q [2];
    logic             pop, issue;
    assign pop = bus.m_valid & bus.m_ready;
    // a read may only launch if its word is guaranteed a buffer slot on arrival
    assign issue = state_q == RUN && issued_q < len_q &&
                   ({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign bus.mem_cenb = !issue;
    assign bus.mem_wenb = 1'b1;
    assign bus.mem_addr = addr_q;
    assign bus.mem_d = '0;
    assign bus.m_valid = count_q != 2'd0;
    assign bus.m_data = buf_q[rd_ptr_q];
    assign busy_o = state_q == RUN;
    assign done_o = done_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q <= 1'b0;
            inflight_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q <= '0;
            len_q <= '0;
            issued_q <= '0;
            popped_q <= '0;
            addr_q <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            done_q <= 1'b0;
            inflight_q <= issue;
            count_q <= count_d;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= bus.mem_q;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (issue) begin
                issued_q <= issued_q + 1'b1;
                addr_q <= addr_q == AW'(SIZE - 1) ? '0 : addr_q + 1'b1;
            end
            if (state_q == IDLE) begin
                if (start_i) begin
                    addr_q <= base_addr_i;
                    len_q <= len_i;
                    issued_q <= '0;
                    popped_q <= '0;
                    state_q <= len_i == '0 ? IDLE : RUN;
                    done_q <= len_i == '0;
                end
            end else if (pop) begin
                popped_q <= popped_q + 1'b1;
                if (popped_q + 1'b1 == len_q) begin
                    state_q <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end
    occupancy_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, count_q} + {2'b0, inflight_q}) <= 3'd2);
endmodule
